// File: rtl/lector_memoria_ventana_pkg.sv
// Shared definitions for the window memory reader: FSM state encoding,
// default widths and a small counter-width helper.
package lector_memoria_ventana_pkg;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        LECTURA = 2'd1,
        DRENAJE = 2'd2,
        FIN     = 2'd3
    } estado_t;

    localparam int BITS_DIRECCION_MEM_DEF = 10;
    localparam int BITS_BUFFERS_DEF       = 3;

    // Width of a counter that holds 0..n-1, never narrower than one bit.
    function automatic int bits_contador(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/FlipFlopD_Habilitado.sv
// Generic enabled D register with asynchronous active-low clear.
module FlipFlopD_Habilitado #(
    parameter int ANCHO = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             habilitar,
    input  logic [ANCHO-1:0] d,
    output logic [ANCHO-1:0] q
);

    // Load d when enabled, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (habilitar)
            q <= d;
    end

endmodule

// File: rtl/lector_memoria_ventana_retardo.sv
// Valid shift register that tracks reads in flight through the memory.
// salida marks the cycle the returned word is on mem_datos_lectura.
// vacio is high when no read is pending beyond the one (if any) leaving
// this cycle, so a drain can finish in the same cycle as the last write.
module linea_retardo_valido #(
    parameter int LATENCIA = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic entrada,
    output logic salida,
    output logic vacio
);

    logic [LATENCIA-1:0] etapas;
    logic [LATENCIA-1:0] pendientes;

    // Shift one valid bit per cycle towards the output stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            etapas <= '0;
        else
            etapas <= (etapas << 1) | LATENCIA'(entrada);
    end

    assign salida     = etapas[LATENCIA-1];
    assign pendientes = etapas << 1;
    assign vacio      = ~|pendientes;

endmodule

// File: rtl/lector_memoria_ventana.sv
// Memory read sequencer for the window line buffer.
// Latches base address, read count and buffer count on inicio, streams
// sequential reads and routes returned words round-robin into the
// internal buffers, PALABRAS_POR_BUFFER words each.
// Optional: define LECTOR_VENTANA_ESTADISTICAS_EN to add ciclos_espera,
// a saturating count of LECTURA cycles stalled by buffer_listo=0.
//
// state   | meaning
// REPOSO  | idle, waiting for inicio
// LECTURA | issuing reads while buffer_listo allows
// DRENAJE | all reads issued, waiting for returns to be written
// FIN     | one-cycle listo pulse
module lector_memoria_ventana
    import lector_memoria_ventana_pkg::*;
#(
    parameter int BITS_DIRECCION_MEM  = BITS_DIRECCION_MEM_DEF,
    parameter int BITS_DATOS_MEM      = 32,
    parameter int BITS_BUFFERS        = BITS_BUFFERS_DEF,
    parameter int PALABRAS_POR_BUFFER = 128,
    parameter int LATENCIA_MEM        = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          inicio,
    input  logic [BITS_DIRECCION_MEM-1:0] direccion_mem_inicio_imagen,
    input  logic [BITS_DIRECCION_MEM-1:0] cantidad_lecturas_mem,
    input  logic [BITS_BUFFERS-1:0]       cantidad_buffers_internos,
    input  logic                          buffer_listo,
    output logic [BITS_DIRECCION_MEM-1:0] mem_direccion,
    output logic                          mem_lectura,
    input  logic [BITS_DATOS_MEM-1:0]     mem_datos_lectura,
    output logic [BITS_DATOS_MEM-1:0]     buffer_datos,
    output logic                          buffer_escritura,
    output logic [BITS_BUFFERS-1:0]       buffer_seleccion,
    output logic                          ocupado,
    output logic                          listo
`ifdef LECTOR_VENTANA_ESTADISTICAS_EN
    ,
    output logic [15:0]                   ciclos_espera
`endif
);

    localparam int BITS_PALABRA = bits_contador(PALABRAS_POR_BUFFER);
    localparam logic [BITS_PALABRA-1:0] ULTIMA_PALABRA = BITS_PALABRA'(PALABRAS_POR_BUFFER - 1);

    estado_t estado, estado_sig;

    logic                          aceptar;
    logic [BITS_DIRECCION_MEM-1:0] base_q;
    logic [BITS_DIRECCION_MEM-1:0] cantidad_q;
    logic [BITS_BUFFERS-1:0]       buffers_q;
    logic [BITS_BUFFERS-1:0]       ultimo_buffer;
    logic [BITS_DIRECCION_MEM-1:0] emitidas;
    logic [BITS_PALABRA-1:0]       palabra;
    logic [BITS_BUFFERS-1:0]       sel;
    logic                          escritura;
    logic                          pipe_vacio;

    assign aceptar = inicio && (estado == REPOSO);

    FlipFlopD_Habilitado #(.ANCHO(BITS_DIRECCION_MEM)) u_base (
        .clk(clk), .reset(reset), .habilitar(aceptar),
        .d(direccion_mem_inicio_imagen), .q(base_q)
    );

    FlipFlopD_Habilitado #(.ANCHO(BITS_DIRECCION_MEM)) u_cantidad (
        .clk(clk), .reset(reset), .habilitar(aceptar),
        .d(cantidad_lecturas_mem), .q(cantidad_q)
    );

    FlipFlopD_Habilitado #(.ANCHO(BITS_BUFFERS)) u_buffers (
        .clk(clk), .reset(reset), .habilitar(aceptar),
        .d(cantidad_buffers_internos), .q(buffers_q)
    );

    linea_retardo_valido #(.LATENCIA(LATENCIA_MEM)) u_retardo (
        .clk(clk), .reset(reset), .entrada(mem_lectura),
        .salida(escritura), .vacio(pipe_vacio)
    );

    // A buffer count of zero behaves as a single buffer.
    assign ultimo_buffer = (buffers_q == '0) ? '0 : buffers_q - BITS_BUFFERS'(1);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            estado <= REPOSO;
        else
            estado <= estado_sig;
    end

    // Next state and read-side outputs.
    always_comb begin
        estado_sig    = estado;
        mem_lectura   = 1'b0;
        mem_direccion = '0;
        ocupado       = 1'b1;
        listo         = 1'b0;
        case (estado)
            REPOSO: begin
                ocupado = 1'b0;
                if (inicio)
                    estado_sig = (cantidad_lecturas_mem == '0) ? FIN : LECTURA;
            end
            LECTURA: begin
                mem_lectura   = buffer_listo;
                mem_direccion = base_q + emitidas;
                if (buffer_listo && (emitidas == cantidad_q - BITS_DIRECCION_MEM'(1)))
                    estado_sig = DRENAJE;
            end
            DRENAJE: begin
                if (pipe_vacio)
                    estado_sig = FIN;
            end
            FIN: begin
                listo      = 1'b1;
                estado_sig = REPOSO;
            end
            default: estado_sig = REPOSO;
        endcase
    end

    // Read issue count and round-robin buffer word/index tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            emitidas <= '0;
            palabra  <= '0;
            sel      <= '0;
        end else if (aceptar) begin
            emitidas <= '0;
            palabra  <= '0;
            sel      <= '0;
        end else begin
            if (mem_lectura)
                emitidas <= emitidas + BITS_DIRECCION_MEM'(1);
            if (escritura) begin
                if (palabra == ULTIMA_PALABRA) begin
                    palabra <= '0;
                    sel     <= (sel == ultimo_buffer) ? '0 : sel + BITS_BUFFERS'(1);
                end else begin
                    palabra <= palabra + BITS_PALABRA'(1);
                end
            end
        end
    end

    // Data is gated so the line buffer sees zero outside write cycles.
    assign buffer_escritura = escritura;
    assign buffer_datos     = escritura ? mem_datos_lectura : '0;
    assign buffer_seleccion = sel;

`ifdef LECTOR_VENTANA_ESTADISTICAS_EN
    // Saturating count of stalled issue cycles for the current run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ciclos_espera <= '0;
        else if (aceptar)
            ciclos_espera <= '0;
        else if ((estado == LECTURA) && !buffer_listo && (ciclos_espera != 16'hFFFF))
            ciclos_espera <= ciclos_espera + 16'd1;
    end
`endif

endmodule

// File: tb/tb_lector_memoria_ventana.sv
// Testbench for lector_memoria_ventana: memory model with fixed latency,
// scoreboard queues of expected addresses and (word, buffer) pairs.
module tb_lector_memoria_ventana;

    localparam int BDM = 10;
    localparam int BD  = 32;
    localparam int BB  = 3;
    localparam int PPB = 4;
    localparam int LAT = 2;
    localparam int PROF = 1 << BDM;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           inicio = 1'b0;
    logic [BDM-1:0] dir_inicio = '0;
    logic [BDM-1:0] cantidad = '0;
    logic [BB-1:0]  buffers = '0;
    logic           buffer_listo = 1'b1;
    logic [BDM-1:0] mem_direccion;
    logic           mem_lectura;
    logic [BD-1:0]  mem_datos_lectura = '0;
    logic [BD-1:0]  buffer_datos;
    logic           buffer_escritura;
    logic [BB-1:0]  buffer_seleccion;
    logic           ocupado;
    logic           listo;
`ifdef LECTOR_VENTANA_ESTADISTICAS_EN
    logic [15:0]    ciclos_espera;
`endif

    lector_memoria_ventana #(
        .BITS_DIRECCION_MEM(BDM), .BITS_DATOS_MEM(BD), .BITS_BUFFERS(BB),
        .PALABRAS_POR_BUFFER(PPB), .LATENCIA_MEM(LAT)
    ) dut (
        .clk(clk), .reset(reset), .inicio(inicio),
        .direccion_mem_inicio_imagen(dir_inicio),
        .cantidad_lecturas_mem(cantidad),
        .cantidad_buffers_internos(buffers),
        .buffer_listo(buffer_listo),
        .mem_direccion(mem_direccion), .mem_lectura(mem_lectura),
        .mem_datos_lectura(mem_datos_lectura),
        .buffer_datos(buffer_datos), .buffer_escritura(buffer_escritura),
        .buffer_seleccion(buffer_seleccion),
        .ocupado(ocupado), .listo(listo)
`ifdef LECTOR_VENTANA_ESTADISTICAS_EN
        , .ciclos_espera(ciclos_espera)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ciclo = 0;

    logic [BD-1:0]  memoria [0:PROF-1];
    logic [BDM-1:0] dir_ret [0:LAT];
    logic           val_ret [0:LAT];

    logic [BDM-1:0] cola_dir[$];
    logic [BD-1:0]  cola_dato[$];
    logic [BB-1:0]  cola_sel[$];

    bit esperando_listo = 1'b0;
    int ciclo_listo = -1;
    int modo_listo = 0;       // 0: always ready, 1: random, 2: 3-cycle pause
    int pausa_desde = 0;

    task automatic verificar(input string nombre, input logic [63:0] actual, input logic [63:0] esperado);
        checks++;
        if (actual !== esperado) begin
            errors++;
            $display("FAIL %s actual=%0d esperado=%0d (t=%0t)", nombre, actual, esperado, $time);
        end
    endtask

    // Memory return path and buffer_listo driver.
    always @(posedge clk) begin
        ciclo = ciclo + 1;
        #1;
        for (int i = LAT; i > 0; i--) begin
            dir_ret[i] = dir_ret[i-1];
            val_ret[i] = val_ret[i-1];
        end
        val_ret[0] = 1'b0;
        mem_datos_lectura = val_ret[LAT] ? memoria[dir_ret[LAT]] : $urandom();
        case (modo_listo)
            0: buffer_listo = 1'b1;
            1: buffer_listo = ($urandom_range(0, 3) != 0);
            default: buffer_listo = !((ciclo >= pausa_desde) && (ciclo < pausa_desde + 3));
        endcase
    end

    // Monitor: compares every strobe, write and listo against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (!buffer_listo) begin
                verificar("sin_lectura_en_pausa", mem_lectura, 0);
                if (ocupado && cola_dir.size() > 0)
                    verificar("direccion_retenida", mem_direccion, cola_dir[0]);
            end
            if (mem_lectura === 1'b1) begin
                val_ret[0] = 1'b1;
                dir_ret[0] = mem_direccion;
                if (cola_dir.size() == 0)
                    verificar("lectura_inesperada", 1, 0);
                else
                    verificar("direccion", mem_direccion, cola_dir.pop_front());
            end
            if (buffer_escritura === 1'b1) begin
                if (cola_dato.size() == 0) begin
                    verificar("escritura_inesperada", 1, 0);
                end else begin
                    verificar("dato", buffer_datos, cola_dato.pop_front());
                    verificar("seleccion", buffer_seleccion, cola_sel.pop_front());
                end
            end
            if (listo === 1'b1) begin
                verificar("listo_esperado", esperando_listo, 1);
                verificar("colas_vacias_en_listo", cola_dir.size() + cola_dato.size(), 0);
                esperando_listo = 1'b0;
                ciclo_listo = ciclo;
            end
        end
    end

    task automatic esperar_reposo();
        int espera;
        espera = 0;
        while (ocupado !== 1'b0 && espera < 5000) begin
            @(posedge clk); #2;
            espera++;
        end
        verificar("reposo_antes_de_inicio", ocupado, 0);
    endtask

    task automatic encolar(input int base, input int cant, input int bufs);
        int nb;
        nb = (bufs == 0) ? 1 : bufs;
        for (int k = 0; k < cant; k++) begin
            cola_dir.push_back(BDM'((base + k) % PROF));
            cola_dato.push_back(memoria[(base + k) % PROF]);
            cola_sel.push_back(BB'((k / PPB) % nb));
        end
    endtask

    // One complete run; optionally checks listo timing (extra = stall cycles).
    task automatic lanzar(input int base, input int cant, input int bufs,
                          input bit revisar_tiempo, input int extra, input bit ruido);
        int c;
        int espera;
        esperar_reposo();
        encolar(base, cant, bufs);
        esperando_listo = 1'b1;
        ciclo_listo = -1;
        @(posedge clk); #2;
        c = ciclo;
        dir_inicio = BDM'(base);
        cantidad   = BDM'(cant);
        buffers    = BB'(bufs);
        inicio     = 1'b1;
        @(posedge clk); #2;
        inicio = 1'b0;
        verificar("ocupado_en_marcha", ocupado, 1);
        if (ruido) begin
            dir_inicio = BDM'($urandom());
            cantidad   = BDM'($urandom());
            buffers    = BB'($urandom());
            inicio     = 1'b1;
            @(posedge clk); #2;
            inicio     = 1'b0;
        end
        espera = 0;
        while (esperando_listo && espera < cant * 8 + 60) begin
            @(posedge clk); #2;
            espera++;
        end
        verificar("listo_a_tiempo", esperando_listo, 0);
        if (revisar_tiempo)
            verificar("ciclo_listo", ciclo_listo - c, (cant == 0) ? 1 : cant + LAT + 1 + extra);
    endtask

    // Reset during LECTURA: outputs clear at once, nothing completes.
    task automatic abortar(input int base, input int cant);
        esperar_reposo();
        encolar(base, cant, 1);
        @(posedge clk); #2;
        dir_inicio = BDM'(base);
        cantidad   = BDM'(cant);
        buffers    = BB'(1);
        inicio     = 1'b1;
        @(posedge clk); #2;
        inicio = 1'b0;
        repeat (4) begin @(posedge clk); #2; end
        verificar("lectura_antes_de_abortar", mem_lectura, 1);
        reset = 1'b0;
        #1;
        verificar("abort_mem_lectura", mem_lectura, 0);
        verificar("abort_mem_direccion", mem_direccion, 0);
        verificar("abort_escritura", buffer_escritura, 0);
        verificar("abort_ocupado", ocupado, 0);
        verificar("abort_listo", listo, 0);
        verificar("abort_seleccion", buffer_seleccion, 0);
        cola_dir.delete();
        cola_dato.delete();
        cola_sel.delete();
        for (int i = 0; i <= LAT; i++) val_ret[i] = 1'b0;
        esperando_listo = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (6) begin @(posedge clk); #2; end
        verificar("sin_actividad_tras_abortar", {ocupado, buffer_escritura, mem_lectura}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout esperado=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < PROF; i++) memoria[i] = $urandom();
        for (int i = 0; i <= LAT; i++) begin
            val_ret[i] = 1'b0;
            dir_ret[i] = '0;
        end
        repeat (2) @(posedge clk);
        #2;
        verificar("reset_mem_lectura", mem_lectura, 0);
        verificar("reset_mem_direccion", mem_direccion, 0);
        verificar("reset_escritura", buffer_escritura, 0);
        verificar("reset_datos", buffer_datos, 0);
        verificar("reset_seleccion", buffer_seleccion, 0);
        verificar("reset_ocupado", ocupado, 0);
        verificar("reset_listo", listo, 0);
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #2; end

        modo_listo = 0;
        lanzar(10, 5, 1, 1'b1, 0, 1'b0);
        lanzar(20, 0, 2, 1'b1, 0, 1'b0);
        lanzar(1020, 8, 2, 1'b1, 0, 1'b0);
        lanzar(300, 14, 3, 1'b1, 0, 1'b0);
        lanzar(40, 9, 0, 1'b1, 0, 1'b1);

        modo_listo = 2;
        pausa_desde = ciclo + 5;
        lanzar(500, 20, 2, 1'b1, 3, 1'b0);
        modo_listo = 0;

        abortar(100, 30);
        lanzar(100, 30, 1, 1'b1, 0, 1'b0);

        modo_listo = 1;
        for (int r = 0; r < 25; r++)
            lanzar($urandom_range(0, PROF - 1), $urandom_range(0, 40), $urandom_range(0, 7), 1'b0, 0, 1'b1);

        modo_listo = 0;
        for (int r = 0; r < 6; r++)
            lanzar($urandom_range(0, PROF - 1), $urandom_range(0, 25), $urandom_range(0, 7), 1'b1, 0, 1'b1);

        esperar_reposo();
        repeat (4) begin @(posedge clk); #2; end
        verificar("escrituras_pendientes_al_final", cola_dato.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
